// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator for the head of the video pipeline.
// Purpose: produces the pixel position (hcount/vcount), sync and blanking flags,
//          a start-of-frame pulse and a completed-frame counter, all registered
//          and mutually aligned (flags decoded from next-state counts).
// Ports:
//   pclk      in   pixel clock, rising edge
//   rst       in   asynchronous active-high reset
//   hcount    out  [10:0] horizontal position 0..H_TOTAL-1
//   hsync     out  horizontal sync, SYNC_POL level inside the sync window
//   hblnk     out  high when hcount >= H_ACTIVE
//   vcount    out  [10:0] vertical position 0..V_TOTAL-1
//   vsync     out  vertical sync, SYNC_POL level inside the sync window
//   vblnk     out  high when vcount >= V_ACTIVE
//   sof       out  high for the single cycle at position (0,0)
//   frame_cnt out  [15:0] completed-frame counter, wraps
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 23,
   parameter logic        SYNC_POL = 1'b1
) (
   input  logic        pclk,
   input  logic        rst,
   output logic [10:0] hcount,
   output logic        hsync,
   output logic        hblnk,
   output logic [10:0] vcount,
   output logic        vsync,
   output logic        vblnk,
   output logic        sof,
   output logic [15:0] frame_cnt
);

   localparam int unsigned CW       = 11;
   localparam int unsigned XW       = CW + 1;  // one extra bit so window ends of 2048 compare correctly
   localparam int unsigned FW       = 16;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Counts must fit the 11-bit position outputs.
   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 2048");
   end

   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          hblnk_q, hblnk_d;
   logic          vblnk_q, vblnk_d;
   logic          sof_q, sof_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;

   logic          h_last;
   logic          v_last;
   logic [XW-1:0] hx;
   logic [XW-1:0] vx;

   // Next position and the flags decoded from it, so flags land with their counts.
   always_comb begin
      h_last      = (hcount_q == CW'(H_TOTAL - 1));
      v_last      = (vcount_q == CW'(V_TOTAL - 1));
      hcount_d    = hcount_q + CW'(1);
      vcount_d    = vcount_q;
      frame_cnt_d = frame_cnt_q;

      if (h_last) begin
         hcount_d = '0;
         if (v_last) begin
            vcount_d    = '0;
            frame_cnt_d = frame_cnt_q + FW'(1);
         end else begin
            vcount_d = vcount_q + CW'(1);
         end
      end

      hx      = {1'b0, hcount_d};
      vx      = {1'b0, vcount_d};
      hblnk_d = (hx >= XW'(H_ACTIVE));
      vblnk_d = (vx >= XW'(V_ACTIVE));
      hsync_d = ((hx >= XW'(HS_START)) && (hx < XW'(HS_END))) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vx >= XW'(VS_START)) && (vx < XW'(VS_END))) ? SYNC_POL : ~SYNC_POL;
      sof_d   = (hcount_d == '0) && (vcount_d == '0);
   end

   // State registers; reset loads the decoded values of position (0,0).
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_q    <= '0;
         vcount_q    <= '0;
         hsync_q     <= ~SYNC_POL;
         vsync_q     <= ~SYNC_POL;
         hblnk_q     <= 1'b0;
         vblnk_q     <= 1'b0;
         sof_q       <= 1'b1;
         frame_cnt_q <= '0;
      end else begin
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         hblnk_q     <= hblnk_d;
         vblnk_q     <= vblnk_d;
         sof_q       <= sof_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign hcount    = hcount_q;
   assign vcount    = vcount_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign hblnk     = hblnk_q;
   assign vblnk     = vblnk_q;
   assign sof       = sof_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three instances (small timing active-high sync,
// small timing active-low sync, default SVGA timing) against an arithmetic
// raster model evaluated from the number of clock edges since reset release.
module tb_vga_timing_gen;

   typedef struct {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic        sof;
      logic [15:0] fc;
   } exp_t;

   // Small timing: 31 x 16 = 496 cycles per frame.
   localparam int SH_A = 16, SH_F = 4, SH_S = 6, SH_B = 5;
   localparam int SV_A = 10, SV_F = 1, SV_S = 2, SV_B = 3;
   localparam int S_FT = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   t = 0;       // rising edges since reset release
   int   f_off = 0;   // frame counter offset applied to the small active-high instance
   int   n_vec = 0;
   int   n_err = 0;

   logic [10:0] s_h, s_v, n_h, n_v, d_h, d_v;
   logic        s_hs, s_vs, s_hb, s_vb, s_sof;
   logic        n_hs, n_vs, n_hb, n_vb, n_sof;
   logic        d_hs, d_vs, d_hb, d_vb, d_sof;
   logic [15:0] s_fc, n_fc, d_fc;

   vga_timing_gen #(.H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
                    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
                    .SYNC_POL(1'b1)) dut_s (
      .pclk(clk), .rst(rst), .hcount(s_h), .hsync(s_hs), .hblnk(s_hb),
      .vcount(s_v), .vsync(s_vs), .vblnk(s_vb), .sof(s_sof), .frame_cnt(s_fc));

   vga_timing_gen #(.H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
                    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
                    .SYNC_POL(1'b0)) dut_n (
      .pclk(clk), .rst(rst), .hcount(n_h), .hsync(n_hs), .hblnk(n_hb),
      .vcount(n_v), .vsync(n_vs), .vblnk(n_vb), .sof(n_sof), .frame_cnt(n_fc));

   vga_timing_gen dut_d (
      .pclk(clk), .rst(rst), .hcount(d_h), .hsync(d_hs), .hblnk(d_hb),
      .vcount(d_v), .vsync(d_vs), .vblnk(d_vb), .sof(d_sof), .frame_cnt(d_fc));

   always #5 clk = ~clk;

   always @(posedge clk) if (!rst) t = t + 1;

   // Raster position and decoded flags after tt edges, from plain arithmetic.
   function automatic exp_t model(input int tt, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb, input logic pol, input int fo);
      exp_t e;
      int ht, vt, h, line, v, frames;
      ht     = ha + hf + hs + hb;
      vt     = va + vf + vs + vb;
      h      = tt % ht;
      line   = tt / ht;
      v      = line % vt;
      frames = line / vt;
      e.h    = 11'(h);
      e.v    = 11'(v);
      e.hb   = (h >= ha);
      e.vb   = (v >= va);
      e.hs   = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
      e.vs   = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
      e.sof  = (h == 0 && v == 0);
      e.fc   = 16'(frames + fo);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input exp_t e, input logic [10:0] h,
                          input logic [10:0] v, input logic hs, input logic vs,
                          input logic hb, input logic vb, input logic sf,
                          input logic [15:0] fc);
      chk({tag, ".hcount"}, 16'(h), 16'(e.h));
      chk({tag, ".vcount"}, 16'(v), 16'(e.v));
      chk({tag, ".hsync"}, 16'(hs), 16'(e.hs));
      chk({tag, ".vsync"}, 16'(vs), 16'(e.vs));
      chk({tag, ".hblnk"}, 16'(hb), 16'(e.hb));
      chk({tag, ".vblnk"}, 16'(vb), 16'(e.vb));
      chk({tag, ".sof"}, 16'(sf), 16'(e.sof));
      chk({tag, ".frame_cnt"}, fc, e.fc);
   endtask

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      cmp_all("s", model(t, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, f_off),
              s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_sof, s_fc);
      cmp_all("n", model(t, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b0, 0),
              n_h, n_v, n_hs, n_vs, n_hb, n_vb, n_sof, n_fc);
      cmp_all("d", model(t, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 0),
              d_h, d_v, d_hs, d_vs, d_hb, d_vb, d_sof, d_fc);
   end

   task automatic step_to(input int n);
      while (t < n) @(negedge clk);
   endtask

   initial begin
      // Reset held from time 0.
      repeat (3) @(negedge clk);
      #1;
      chk("rst.hcount", 16'(s_h), 16'd0);
      chk("rst.vcount", 16'(s_v), 16'd0);
      chk("rst.hsync", 16'(s_hs), 16'd0);
      chk("rst.sof", 16'(s_sof), 16'd1);
      chk("rst.frame_cnt", s_fc, 16'd0);
      chk("rst.n_hsync", 16'(n_hs), 16'd1);
      rst = 1'b0;

      step_to(1);    chk("rel.hcount", 16'(s_h), 16'd1);  chk("rel.sof", 16'(s_sof), 16'd0);
      step_to(15);   chk("h15.hblnk", 16'(s_hb), 16'd0);
      step_to(16);   chk("h16.hblnk", 16'(s_hb), 16'd1);
      step_to(19);   chk("h19.hsync", 16'(s_hs), 16'd0);
      step_to(20);   chk("h20.hsync", 16'(s_hs), 16'd1);
      step_to(25);   chk("h25.hsync", 16'(s_hs), 16'd1);
      step_to(26);   chk("h26.hsync", 16'(s_hs), 16'd0);
      step_to(30);   chk("h30.hcount", 16'(s_h), 16'd30);
      step_to(31);   chk("wrap.hcount", 16'(s_h), 16'd0); chk("wrap.vcount", 16'(s_v), 16'd1);
      step_to(82);   chk("n.hsync_low", 16'(n_hs), 16'd0);
      step_to(309);  chk("v9.vblnk", 16'(s_vb), 16'd0);
      step_to(310);  chk("v10.vblnk", 16'(s_vb), 16'd1);
      step_to(340);  chk("v10h30.vsync", 16'(s_vs), 16'd0);
      step_to(341);  chk("v11h0.vsync", 16'(s_vs), 16'd1);
      step_to(402);  chk("v12h30.vsync", 16'(s_vs), 16'd1);
      step_to(403);  chk("v13h0.vsync", 16'(s_vs), 16'd0);
      step_to(495);  chk("eof.frame_cnt", s_fc, 16'd0);   chk("eof.sof", 16'(s_sof), 16'd0);
      step_to(496);  chk("sof1.sof", 16'(s_sof), 16'd1);  chk("sof1.frame_cnt", s_fc, 16'd1);
      step_to(799);  chk("d799.hblnk", 16'(d_hb), 16'd0);
      step_to(800);  chk("d800.hblnk", 16'(d_hb), 16'd1);
      step_to(839);  chk("d839.hsync", 16'(d_hs), 16'd0);
      step_to(840);  chk("d840.hsync", 16'(d_hs), 16'd1);
      step_to(967);  chk("d967.hsync", 16'(d_hs), 16'd1);
      step_to(968);  chk("d968.hsync", 16'(d_hs), 16'd0);
      step_to(992);  chk("sof2.frame_cnt", s_fc, 16'd2);
      step_to(1055); chk("d1055.hcount", 16'(d_h), 16'd1055);
      step_to(1056); chk("dwrap.hcount", 16'(d_h), 16'd0); chk("dwrap.vcount", 16'(d_v), 16'd1);

      // Asynchronous reset mid-frame, between clock edges.
      step_to(1200);
      @(posedge clk);
      #2;
      rst   = 1'b1;
      t     = 0;
      f_off = 0;
      #1;
      chk("arst.hcount", 16'(s_h), 16'd0);
      chk("arst.vcount", 16'(s_v), 16'd0);
      chk("arst.sof", 16'(s_sof), 16'd1);
      chk("arst.frame_cnt", s_fc, 16'd0);
      chk("arst.d_hcount", 16'(d_h), 16'd0);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      step_to(495);  chk("rr.eof.frame_cnt", s_fc, 16'd0);
      step_to(496);  chk("rr.sof", 16'(s_sof), 16'd1); chk("rr.frame_cnt", s_fc, 16'd1);

      // Preload the frame counter to 0xFFFF mid-frame, then let the frame complete.
      step_to(599);
      force dut_s.frame_cnt_d = 16'hFFFF;
      @(posedge clk);
      #1;
      f_off = 16'hFFFF - (t / S_FT);
      @(negedge clk);
      release dut_s.frame_cnt_d;
      step_to(991);  chk("pre_wrap.frame_cnt", s_fc, 16'hFFFF);
      step_to(992);  chk("wrap16.frame_cnt", s_fc, 16'h0000); chk("wrap16.sof", 16'(s_sof), 16'd1);
      step_to(1100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
